// File: rtl/bus_bridge.sv
// bus_bridge: single-master CPU bridge to two timer devices plus a small
// interrupt controller. Each request walks IDLE -> ACCESS -> DONE; the
// completion pulse on cpu_ready is registered out of DONE.
module bus_bridge #(
    parameter logic [31:0] DEV0_BASE = 32'h0000_7F00,
    parameter logic [31:0] DEV1_BASE = 32'h0000_7F10,
    parameter logic [31:0] ICTL_BASE = 32'h0000_7F20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic [5:0]  cpu_hwint,
    output logic [1:0]  dev_addr,
    output logic [31:0] dev_wdata,
    output logic        dev_we0,
    output logic        dev_we1,
    input  logic [31:0] dev_rdata0,
    input  logic [31:0] dev_rdata1,
    input  logic        dev_irq0,
    input  logic        dev_irq1
);
    localparam logic [31:0] UNMAPPED_DATA = 32'hABCD_EEFF;
    localparam logic [31:0] WINDOW_BYTES  = 32'd12;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [29:0] r_addr;
    logic        r_we;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_ready;
    logic [1:0]  r_pend;
    logic [1:0]  r_mask;

    logic        w_latch;
    logic        w_access;
    logic [31:0] w_byte_addr;
    logic [31:0] w_off0;
    logic [31:0] w_off1;
    logic [31:0] w_offi;
    logic        w_hit0;
    logic        w_hit1;
    logic        w_hiti;
    logic [31:0] w_rdata_sel;
    logic [1:0]  w_clr;
    logic        w_mask_we;
    logic        w_unused;

    // Byte-address bits [1:0] carry no information for word registers.
    assign w_unused = &{1'b0, cpu_addr[1:0]};

    // Window decode on the latched word address; offsets 0, 4, 8 are mapped,
    // anything from offset 12 upward falls through to the unmapped response.
    assign w_byte_addr = {r_addr, 2'b00};
    assign w_off0      = w_byte_addr - DEV0_BASE;
    assign w_off1      = w_byte_addr - DEV1_BASE;
    assign w_offi      = w_byte_addr - ICTL_BASE;
    assign w_hit0      = (w_off0 < WINDOW_BYTES);
    assign w_hit1      = (w_off1 < WINDOW_BYTES) && !w_hit0;
    assign w_hiti      = (w_offi < WINDOW_BYTES) && !w_hit0 && !w_hit1;

    // The access cycle is gated by rst so a reset landing on the ACCESS edge
    // never lets a device commit the write on that same edge.
    assign w_access  = (r_state == ACCESS) && !rst;
    assign dev_we0   = w_access && r_we && w_hit0;
    assign dev_we1   = w_access && r_we && w_hit1;
    assign w_mask_we = w_access && r_we && w_hiti && (w_offi[3:2] == 2'b01);
    assign w_clr     = (w_access && r_we && w_hiti && (w_offi[3:2] == 2'b00))
                       ? r_wdata[1:0] : 2'b00;

    assign dev_addr  = r_addr[1:0];
    assign dev_wdata = r_wdata;
    assign cpu_rdata = r_rdata;
    assign cpu_ready = r_ready;
    assign cpu_hwint = {4'b0000, r_pend & r_mask};

    // Next-state logic; IDLE ignores cpu_req during the ready cycle because
    // the CPU is still holding the completed request at that point.
    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        case (r_state)
            IDLE: begin
                if (cpu_req && !r_ready) begin
                    w_latch      = 1'b1;
                    w_state_next = ACCESS;
                end
            end
            ACCESS:  w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Read-data mux for the selected window.
    always_comb begin
        w_rdata_sel = UNMAPPED_DATA;
        if (w_hit0) begin
            w_rdata_sel = dev_rdata0;
        end else if (w_hit1) begin
            w_rdata_sel = dev_rdata1;
        end else if (w_hiti) begin
            case (w_offi[3:2])
                2'b00:   w_rdata_sel = {30'd0, r_pend};
                2'b01:   w_rdata_sel = {30'd0, r_mask};
                default: w_rdata_sel = 32'd0;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Request latch: address, direction and write data captured in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else if (w_latch) begin
            r_addr  <= cpu_addr[31:2];
            r_we    <= cpu_we;
            r_wdata <= cpu_wdata;
        end
    end

    // Read data captured at the end of ACCESS and held until the next read.
    always_ff @(posedge clk) begin
        if (rst)                              r_rdata <= '0;
        else if (r_state == ACCESS && !r_we)  r_rdata <= w_rdata_sel;
    end

    // Completion pulse registered out of DONE; reset on that edge kills it.
    always_ff @(posedge clk) begin
        if (rst) r_ready <= 1'b0;
        else     r_ready <= (r_state == DONE);
    end

    // Pending bits: level set from the devices wins over a same-cycle W1C.
    always_ff @(posedge clk) begin
        if (rst) r_pend <= 2'b00;
        else     r_pend <= (r_pend & ~w_clr) | {dev_irq1, dev_irq0};
    end

    // Interrupt mask register.
    always_ff @(posedge clk) begin
        if (rst)            r_mask <= 2'b00;
        else if (w_mask_we) r_mask <= r_wdata[1:0];
    end
endmodule

// File: tb/tb_bus_bridge.sv
// Directed bench for bus_bridge: a vector table of single transfers followed
// by hand-written interrupt and mid-transfer reset sequences.
module tb_bus_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic [5:0]  cpu_hwint;
    logic [1:0]  dev_addr;
    logic [31:0] dev_wdata;
    logic        dev_we0;
    logic        dev_we1;
    logic [31:0] dev_rdata0 = '0;
    logic [31:0] dev_rdata1 = '0;
    logic        dev_irq0 = 1'b0;
    logic        dev_irq1 = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    bus_bridge dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .cpu_hwint(cpu_hwint), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
        .dev_we0(dev_we0), .dev_we1(dev_we1),
        .dev_rdata0(dev_rdata0), .dev_rdata1(dev_rdata1),
        .dev_irq0(dev_irq0), .dev_irq1(dev_irq1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [31:0] exp_rdata;
        int          exp_n0;
        int          exp_n1;
        logic [1:0]  exp_da;
    } vec_t;

    vec_t vecs[14];

    // Results of the last transfer.
    logic [31:0] t_rdata;
    int          t_lat;
    int          t_n0;
    int          t_n1;
    logic [1:0]  t_da;
    logic [31:0] t_dwd;
    logic        t_ok;
    logic        t_extra_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One CPU transfer; lat is the number of edges from the sampling edge
    // (edge 1) until cpu_ready is seen, so ready after edge N+2 gives 3.
    task automatic xact(input logic [31:0] a, input logic we, input logic [31:0] wd);
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = a; cpu_we = we; cpu_wdata = wd;
        t_n0 = 0; t_n1 = 0; t_lat = 0; t_ok = 1'b0;
        t_da = '0; t_dwd = '0; t_rdata = '0; t_extra_ready = 1'b0;
        for (int c = 1; c <= 10 && !t_ok; c++) begin
            @(negedge clk);
            if (dev_we0) begin t_n0++; t_da = dev_addr; t_dwd = dev_wdata; end
            if (dev_we1) begin t_n1++; t_da = dev_addr; t_dwd = dev_wdata; end
            if (cpu_ready) begin
                t_ok = 1'b1; t_lat = c; t_rdata = cpu_rdata; cpu_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        @(negedge clk);
        if (cpu_ready) t_extra_ready = 1'b1;
        if (dev_we0) t_n0++;
        if (dev_we1) t_n1++;
        $display("xact addr=%h we=%0b wdata=%h rdata=%h lat=%0d we0=%0d we1=%0d done=%0b",
                 a, we, wd, t_rdata, t_lat, t_n0, t_n1, t_ok);
        check("timeout", {31'd0, t_ok}, 32'd1);
    endtask

    initial begin
        vecs[0]  = '{32'h0000_7F04, 1'b1, 32'h0000_0005, 32'h0, 32'h0,         32'h0,         1, 0, 2'b01};
        vecs[1]  = '{32'h0000_7F18, 1'b0, 32'h0,         32'h0, 32'h0000_1234, 32'h0000_1234, 0, 0, 2'b00};
        vecs[2]  = '{32'h0000_7F0C, 1'b0, 32'h0,         32'h1, 32'h2,         32'hABCD_EEFF, 0, 0, 2'b00};
        vecs[3]  = '{32'h0000_8000, 1'b0, 32'h0,         32'h1, 32'h2,         32'hABCD_EEFF, 0, 0, 2'b00};
        vecs[4]  = '{32'h0000_7F0C, 1'b1, 32'h1111_2222, 32'h0, 32'h0,         32'h0,         0, 0, 2'b00};
        vecs[5]  = '{32'h0000_7F18, 1'b1, 32'h0000_CAFE, 32'h0, 32'h0,         32'h0,         0, 1, 2'b10};
        vecs[6]  = '{32'h0000_7F00, 1'b0, 32'h0,         32'h5555_AAAA, 32'h9, 32'h5555_AAAA, 0, 0, 2'b00};
        vecs[7]  = '{32'h0000_7F28, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0,         32'h0,         0, 0, 2'b00};
        vecs[8]  = '{32'h0000_7F24, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0,         32'h0,         0, 0, 2'b00};
        vecs[9]  = '{32'h0000_7F24, 1'b0, 32'h0,         32'h7, 32'h8,         32'h0000_0003, 0, 0, 2'b00};
        vecs[10] = '{32'h0000_7F28, 1'b0, 32'h0,         32'h7, 32'h8,         32'h0000_0000, 0, 0, 2'b00};
        vecs[11] = '{32'h0000_7F1C, 1'b0, 32'h0,         32'h7, 32'h8,         32'hABCD_EEFF, 0, 0, 2'b00};
        vecs[12] = '{32'h0000_7F20, 1'b0, 32'h0,         32'h7, 32'h8,         32'h0000_0000, 0, 0, 2'b00};
        vecs[13] = '{32'h0000_7F1B, 1'b0, 32'h0,         32'h7, 32'h0000_0077, 32'h0000_0077, 0, 0, 2'b00};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready", {31'd0, cpu_ready}, 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_we", {30'd0, dev_we1, dev_we0}, 32'd0);
        check("rst_hwint", {26'd0, cpu_hwint}, 32'd0);
        check("rst_wdata", dev_wdata, 32'd0);
        check("rst_daddr", {30'd0, dev_addr}, 32'd0);

        // Vector table.
        for (int i = 0; i < 14; i++) begin
            dev_rdata0 = vecs[i].rd0;
            dev_rdata1 = vecs[i].rd1;
            xact(vecs[i].addr, vecs[i].we, vecs[i].wdata);
            check($sformatf("v%0d_lat", i), t_lat, 32'd3);
            check($sformatf("v%0d_pulse", i), {31'd0, t_extra_ready}, 32'd0);
            check($sformatf("v%0d_we0", i), t_n0, vecs[i].exp_n0);
            check($sformatf("v%0d_we1", i), t_n1, vecs[i].exp_n1);
            if (!vecs[i].we)
                check($sformatf("v%0d_rdata", i), t_rdata, vecs[i].exp_rdata);
            if (vecs[i].exp_n0 + vecs[i].exp_n1 > 0) begin
                check($sformatf("v%0d_daddr", i), {30'd0, t_da}, {30'd0, vecs[i].exp_da});
                check($sformatf("v%0d_dwdata", i), t_dwd, vecs[i].wdata);
            end
        end

        // One-cycle irq0 pulse with MASK=3 latches PEND[0]; W1C clears it.
        @(negedge clk); dev_irq0 = 1'b1;
        @(negedge clk); dev_irq0 = 1'b0;
        check("irq0_hwint", {26'd0, cpu_hwint}, 32'h01);
        repeat (3) @(negedge clk);
        check("irq0_held", {26'd0, cpu_hwint}, 32'h01);
        xact(32'h0000_7F20, 1'b0, 32'h0);
        check("irq0_pend", t_rdata, 32'h1);
        xact(32'h0000_7F20, 1'b1, 32'h1);
        check("irq0_w1c_we", t_n0 + t_n1, 32'd0);
        @(negedge clk);
        check("irq0_clr", {26'd0, cpu_hwint}, 32'h00);

        // irq1 held high: the set beats a same-cycle W1C.
        @(negedge clk); dev_irq1 = 1'b1;
        xact(32'h0000_7F20, 1'b1, 32'h2);
        check("irq1_hold_hwint", {26'd0, cpu_hwint}, 32'h02);
        xact(32'h0000_7F20, 1'b0, 32'h0);
        check("irq1_hold_pend", t_rdata, 32'h2);
        @(negedge clk); dev_irq1 = 1'b0;
        xact(32'h0000_7F20, 1'b1, 32'h2);
        @(negedge clk);
        check("irq1_clr", {26'd0, cpu_hwint}, 32'h00);

        // Reset arriving during ACCESS of a write aborts it.
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 32'h0000_7F04; cpu_we = 1'b1; cpu_wdata = 32'h0000_0009;
        @(posedge clk);
        #1;
        rst = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        check("abort_we_access", {30'd0, dev_we1, dev_we0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        t_n0 = 0; t_n1 = 0; t_extra_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (dev_we0) t_n0++;
            if (dev_we1) t_n1++;
            if (cpu_ready) t_extra_ready = 1'b1;
        end
        check("abort_we", t_n0 + t_n1, 32'd0);
        check("abort_ready", {31'd0, t_extra_ready}, 32'd0);
        check("abort_rdata", cpu_rdata, 32'd0);
        xact(32'h0000_7F04, 1'b1, 32'h0000_0009);
        check("reissue_lat", t_lat, 32'd3);
        check("reissue_we0", t_n0, 32'd1);
        check("reissue_we1", t_n1, 32'd0);
        check("reissue_daddr", {30'd0, t_da}, 32'd1);
        check("reissue_dwdata", t_dwd, 32'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
